pzbcm_fifo_data_buffer: RTL and testbench



---
 rtl/pzbcm_fifo_pkg.sv | 16 +
 rtl/pzbcm_fifo_ram.sv | 26 ++
 rtl/pzbcm_fifo_data_buffer.sv | 125 ++++++++++++
 tb/tb_pzbcm_fifo_data_buffer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pzbcm_fifo_pkg.sv
// rtl/pzbcm_fifo_pkg.sv - shared error struct and o_error bit indices for the FIFO data path
package pzbcm_fifo_pkg;

  typedef struct packed {
    logic ff_empty_pop;
    logic ff_clobber;
    logic underflow;
    logic overwrite;
  } pzbcm_fifo_error;

  localparam int ERROR_OVERWRITE    = 0;
  localparam int ERROR_UNDERFLOW    = 1;
  localparam int ERROR_FF_CLOBBER   = 2;
  localparam int ERROR_FF_EMPTY_POP = 3;

endpackage

// File: rtl/pzbcm_fifo_ram.sv
// rtl/pzbcm_fifo_ram.sv - FIFO storage array: one write port, one asynchronous read port, no reset
module pzbcm_fifo_ram #(
  parameter type TYPE          = logic,
  parameter int  WORDS         = 4,
  parameter int  POINTER_WIDTH = 2
)(
  input  logic                     i_clk,
  input  logic                     i_write_enable,
  input  logic [POINTER_WIDTH-1:0] i_write_pointer,
  input  TYPE                      i_write_data,
  input  logic [POINTER_WIDTH-1:0] i_read_pointer,
  output TYPE                      o_read_data
);

  TYPE mem [WORDS];

  // Callers guarantee pointers are in range whenever the result is used.
  always_ff @(posedge i_clk) begin
    if (i_write_enable) begin
      mem[i_write_pointer] <= i_write_data;
    end
  end

  assign o_read_data = mem[i_read_pointer];

endmodule

// File: rtl/pzbcm_fifo_data_buffer.sv
// rtl/pzbcm_fifo_data_buffer.sv - FIFO data path: RAM slots, optional head register, sticky protocol errors
module pzbcm_fifo_data_buffer
  import pzbcm_fifo_pkg::*;
#(
  parameter type TYPE              = logic,
  parameter int  DEPTH             = 8,
  parameter bit  DATA_FF_OUT       = 1,
  parameter int  RAM_WORDS         = DATA_FF_OUT ? DEPTH - 1 : DEPTH,
  parameter int  RAM_POINTER_WIDTH = (RAM_WORDS >= 2) ? $clog2(RAM_WORDS) : 1
)(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic [RAM_POINTER_WIDTH-1:0] i_write_pointer,
  input  logic                         i_write_to_ff,
  input  logic                         i_write_to_ram,
  input  TYPE                          i_data,
  input  logic [RAM_POINTER_WIDTH-1:0] i_read_pointer,
  input  logic                         i_read_from_ram,
  input  logic                         i_pop,
  output TYPE                          o_data,
  output logic                         o_valid,
  output logic [3:0]                   o_error
);

  localparam logic [RAM_POINTER_WIDTH:0] SLOTS = RAM_WORDS[RAM_POINTER_WIDTH:0];

  logic                 run;
  logic                 write_in_range;
  logic                 read_in_range;
  logic                 ram_we;
  logic                 occ_w;
  logic                 occ_r;
  logic                 same_slot_read;
  logic                 head_valid;
  logic [RAM_WORDS-1:0] occ;
  logic [3:0]           error_set;
  pzbcm_fifo_error      error_q;
  TYPE                  ram_raw;
  TYPE                  ram_rdata;

  // Reset and clear both beat every strobe, including the RAM write.
  assign run            = i_rst_n && !i_clear;
  assign write_in_range = {1'b0, i_write_pointer} < SLOTS;
  assign read_in_range  = {1'b0, i_read_pointer} < SLOTS;
  assign ram_we         = run && i_write_to_ram && write_in_range;
  assign occ_w          = write_in_range && occ[i_write_pointer];
  assign occ_r          = read_in_range && occ[i_read_pointer];
  assign same_slot_read = i_read_from_ram && read_in_range && (i_read_pointer == i_write_pointer);
  assign ram_rdata      = read_in_range ? ram_raw : '0;

  pzbcm_fifo_ram #(
    .TYPE          (TYPE),
    .WORDS         (RAM_WORDS),
    .POINTER_WIDTH (RAM_POINTER_WIDTH)
  ) u_ram (
    .i_clk           (i_clk),
    .i_write_enable  (ram_we),
    .i_write_pointer (i_write_pointer),
    .i_write_data    (i_data),
    .i_read_pointer  (i_read_pointer),
    .o_read_data     (ram_raw)
  );

  // A same-slot write lands after the read clear, so the slot ends occupied.
  always_ff @(posedge i_clk) begin
    if (!run) begin
      occ <= '0;
    end else begin
      if (i_read_from_ram && read_in_range) begin
        occ[i_read_pointer] <= 1'b0;
      end
      if (ram_we) begin
        occ[i_write_pointer] <= 1'b1;
      end
    end
  end

  always_comb begin
    error_set                     = '0;
    error_set[ERROR_OVERWRITE]    = i_write_to_ram && (!write_in_range || (occ_w && !same_slot_read));
    error_set[ERROR_UNDERFLOW]    = i_read_from_ram && !occ_r;
    error_set[ERROR_FF_CLOBBER]   = i_write_to_ff && (!DATA_FF_OUT || (head_valid && !i_pop));
    error_set[ERROR_FF_EMPTY_POP] = i_pop && !head_valid;
  end

  always_ff @(posedge i_clk) begin
    if (!run) begin
      error_q <= '0;
    end else begin
      error_q <= pzbcm_fifo_error'(error_q | error_set);
    end
  end

  assign o_error = error_q;

  if (DATA_FF_OUT) begin : g_ff_out
    TYPE  data_q;
    logic valid_q;

    always_ff @(posedge i_clk) begin
      if (!run) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (i_write_to_ff) begin
        data_q  <= i_data;
        valid_q <= 1'b1;
      end else if (i_read_from_ram) begin
        data_q  <= ram_rdata;
        valid_q <= 1'b1;
      end else if (i_pop) begin
        valid_q <= 1'b0;
      end
    end

    assign o_data     = data_q;
    assign head_valid = valid_q;
  end else begin : g_ram_out
    assign o_data     = ram_rdata;
    assign head_valid = occ_r;
  end

  assign o_valid = head_valid;

endmodule

// File: tb/tb_pzbcm_fifo_data_buffer.sv
// tb/tb_pzbcm_fifo_data_buffer.sv - scoreboard bench for FF-out and RAM-out builds of the FIFO data buffer
module tb_pzbcm_fifo_data_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       valid;
    logic [7:0] data;
    logic [3:0] err;
    bit         chk_data;
  } exp_t;

  exp_t qf[$];
  exp_t qr[$];
  exp_t mon_f;
  exp_t mon_r;
  int   total = 0;
  int   bad   = 0;

  logic       f_rst_n = 1'b0, f_clear = 1'b0, f_wff = 1'b0, f_wram = 1'b0, f_rram = 1'b0, f_pop = 1'b0;
  logic [1:0] f_wp = '0, f_rp = '0;
  logic [7:0] f_din = '0;
  logic [7:0] f_dout;
  logic       f_valid;
  logic [3:0] f_err;

  logic       r_rst_n = 1'b0, r_clear = 1'b0, r_wff = 1'b0, r_wram = 1'b0, r_rram = 1'b0, r_pop = 1'b0;
  logic [1:0] r_wp = '0, r_rp = '0;
  logic [7:0] r_din = '0;
  logic [7:0] r_dout;
  logic       r_valid;
  logic [3:0] r_err;

  pzbcm_fifo_data_buffer #(
    .TYPE (logic [7:0]), .DEPTH (4), .DATA_FF_OUT (1'b1)
  ) dut_ff (
    .i_clk (clk), .i_rst_n (f_rst_n), .i_clear (f_clear),
    .i_write_pointer (f_wp), .i_write_to_ff (f_wff), .i_write_to_ram (f_wram), .i_data (f_din),
    .i_read_pointer (f_rp), .i_read_from_ram (f_rram), .i_pop (f_pop),
    .o_data (f_dout), .o_valid (f_valid), .o_error (f_err)
  );

  pzbcm_fifo_data_buffer #(
    .TYPE (logic [7:0]), .DEPTH (4), .DATA_FF_OUT (1'b0)
  ) dut_ram (
    .i_clk (clk), .i_rst_n (r_rst_n), .i_clear (r_clear),
    .i_write_pointer (r_wp), .i_write_to_ff (r_wff), .i_write_to_ram (r_wram), .i_data (r_din),
    .i_read_pointer (r_rp), .i_read_from_ram (r_rram), .i_pop (r_pop),
    .o_data (r_dout), .o_valid (r_valid), .o_error (r_err)
  );

  task automatic drive(input bit sel, input string name,
                       input logic rst_n, input logic clear, input logic wff, input logic wram,
                       input logic [1:0] wp, input logic [7:0] d, input logic rram,
                       input logic [1:0] rp, input logic pop,
                       input logic ev, input logic [7:0] ed, input logic [3:0] ee, input bit cd);
    exp_t e;
    @(negedge clk);
    f_rst_n = 1'b1; f_clear = 1'b0; f_wff = 1'b0; f_wram = 1'b0; f_rram = 1'b0; f_pop = 1'b0;
    r_rst_n = 1'b1; r_clear = 1'b0; r_wff = 1'b0; r_wram = 1'b0; r_rram = 1'b0; r_pop = 1'b0;
    e.name = name; e.valid = ev; e.data = ed; e.err = ee; e.chk_data = cd;
    if (!sel) begin
      f_rst_n = rst_n; f_clear = clear; f_wff = wff; f_wram = wram; f_wp = wp; f_din = d;
      f_rram = rram; f_rp = rp; f_pop = pop;
      qf.push_back(e);
    end else begin
      r_rst_n = rst_n; r_clear = clear; r_wff = wff; r_wram = wram; r_wp = wp; r_din = d;
      r_rram = rram; r_rp = rp; r_pop = pop;
      qr.push_back(e);
    end
  endtask

  task automatic check(input string tag, input exp_t e, input logic v, input logic [7:0] d, input logic [3:0] er);
    total++;
    if (v !== e.valid) begin
      bad++;
      $display("FAIL %s/%s valid got=%0b want=%0b", tag, e.name, v, e.valid);
    end
    total++;
    if (er !== e.err) begin
      bad++;
      $display("FAIL %s/%s error got=%b want=%b", tag, e.name, er, e.err);
    end
    if (e.chk_data) begin
      total++;
      if (d !== e.data) begin
        bad++;
        $display("FAIL %s/%s data got=%h want=%h", tag, e.name, d, e.data);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (qf.size() != 0) begin
      mon_f = qf.pop_front();
      check("ff", mon_f, f_valid, f_dout, f_err);
    end
    if (qr.size() != 0) begin
      mon_r = qr.pop_front();
      check("ram", mon_r, r_valid, r_dout, r_err);
    end
  end

  initial begin
    //    sel name          rst clr wff wram wp  data   rram rp  pop  valid data   err   chk
    drive(0, "rst",         0,  0,  0,  0,   0,  8'h00, 0,   0,  0,   0,    8'h00, 4'h0, 1);
    drive(0, "push_ff",     1,  0,  1,  0,   0,  8'h11, 0,   0,  0,   1,    8'h11, 4'h0, 1);
    drive(0, "push_r0",     1,  0,  0,  1,   0,  8'h22, 0,   0,  0,   1,    8'h11, 4'h0, 1);
    drive(0, "push_r1",     1,  0,  0,  1,   1,  8'h33, 0,   0,  0,   1,    8'h11, 4'h0, 1);
    drive(0, "push_r2",     1,  0,  0,  1,   2,  8'h44, 0,   0,  0,   1,    8'h11, 4'h0, 1);
    drive(0, "pop1",        1,  0,  0,  0,   0,  8'h00, 1,   0,  1,   1,    8'h22, 4'h0, 1);
    drive(0, "pop2",        1,  0,  0,  0,   0,  8'h00, 1,   1,  1,   1,    8'h33, 4'h0, 1);
    drive(0, "pop3",        1,  0,  0,  0,   0,  8'h00, 1,   2,  1,   1,    8'h44, 4'h0, 1);
    drive(0, "pop4",        1,  0,  0,  0,   0,  8'h00, 0,   0,  1,   0,    8'h44, 4'h0, 1);
    drive(0, "w2_aa",       1,  0,  0,  1,   2,  8'hAA, 0,   0,  0,   0,    8'h44, 4'h0, 1);
    drive(0, "same_slot",   1,  0,  0,  1,   2,  8'hBB, 1,   2,  0,   1,    8'hAA, 4'h0, 1);
    drive(0, "slot2_kept",  1,  0,  0,  0,   0,  8'h00, 1,   2,  1,   1,    8'hBB, 4'h0, 1);
    drive(0, "w1_55",       1,  0,  0,  1,   1,  8'h55, 0,   0,  0,   1,    8'hBB, 4'h0, 1);
    drive(0, "w1_66_ovw",   1,  0,  0,  1,   1,  8'h66, 0,   0,  0,   1,    8'hBB, 4'h1, 1);
    drive(0, "sticky",      1,  0,  0,  0,   0,  8'h00, 0,   0,  0,   1,    8'hBB, 4'h1, 1);
    drive(0, "clear",       1,  1,  0,  0,   0,  8'h00, 0,   0,  0,   0,    8'h00, 4'h0, 1);
    drive(0, "empty_pop",   1,  0,  0,  0,   0,  8'h00, 0,   0,  1,   0,    8'h00, 4'h8, 1);
    drive(0, "rst_traffic", 0,  0,  1,  1,   0,  8'h77, 0,   0,  1,   0,    8'h00, 4'h0, 1);
    drive(0, "post_rst",    1,  0,  1,  0,   0,  8'h99, 0,   0,  0,   1,    8'h99, 4'h0, 1);
    drive(0, "underflow",   1,  0,  0,  0,   0,  8'h00, 1,   0,  1,   1,    8'h22, 4'h2, 1);
    drive(0, "clobber",     1,  0,  1,  0,   0,  8'h12, 0,   0,  0,   1,    8'h12, 4'h6, 1);
    drive(0, "pipe",        1,  0,  0,  1,   0,  8'h5A, 1,   1,  1,   1,    8'h66, 4'h6 | 4'h2, 1);
    drive(0, "ptr_oob",     1,  0,  0,  1,   3,  8'hC3, 0,   0,  0,   1,    8'h66, 4'h7, 1);
    drive(0, "idle",        1,  0,  0,  0,   0,  8'h00, 0,   0,  0,   1,    8'h66, 4'h7, 1);

    drive(1, "r_rst",       0,  0,  0,  0,   0,  8'h00, 0,   0,  0,   0,    8'h00, 4'h0, 0);
    drive(1, "r_wa5",       1,  0,  0,  1,   0,  8'hA5, 0,   0,  0,   1,    8'hA5, 4'h0, 1);
    drive(1, "r_read",      1,  0,  0,  0,   0,  8'h00, 1,   0,  0,   0,    8'hA5, 4'h0, 1);
    drive(1, "r_wff",       1,  0,  1,  0,   0,  8'h11, 0,   0,  0,   0,    8'hA5, 4'h4, 1);
    drive(1, "r_w3",        1,  0,  0,  1,   3,  8'h3C, 0,   3,  0,   1,    8'h3C, 4'h4, 1);
    drive(1, "r_comb",      1,  0,  0,  0,   0,  8'h00, 0,   0,  0,   0,    8'hA5, 4'h4, 1);
    drive(1, "r_comb3",     1,  0,  0,  0,   0,  8'h00, 0,   3,  0,   1,    8'h3C, 4'h4, 1);

    for (int i = 0; i < 10 && (qf.size() != 0 || qr.size() != 0); i++) begin
      @(posedge clk);
      #2;
    end
    if (qf.size() != 0 || qr.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending got=%0d want=0", qf.size() + qr.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
